pc_seq_ctrl: RTL and testbench
==============================

Name: pc_seq_ctrl

Overview:
- Parametrised program-counter sequencer for the single-cycle CPU; next generation of the basic PC register.
- Adds stall, branch/jump redirect, cause-indexed exception vectors, an internal EPC and ERET return.
- Adds nested-exception (double-fault) halt detection, misaligned-target trapping and a saturating exception counter.
- Sits between the next-PC logic and instruction memory; the CP0 block reads `epc`, `in_handler` and `exc_cnt`.

Parameters:
- ADDR_W, 32, PC/address width.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- EXC_BASE, 32'h0000_0800, base address of the exception vector table.
- CAUSE_W, 3, width of the exception cause code.
- VEC_SHIFT, 4, log2 of the byte spacing between vectors (16 B per cause).
- MISALIGN_CAUSE, 3'b111, cause code used for internally detected misaligned targets.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- stall  in  1  hold the PC this cycle.
- br_valid  in  1  branch/jump redirect request.
- br_target  in  ADDR_W  redirect address.
- exc_req  in  1  synchronous exception request from the datapath.
- exc_cause  in  CAUSE_W  cause code of the exception request.
- eret  in  1  return-from-exception (decoded COP0 ERET).
- pc  out  ADDR_W  current fetch address.
- epc  out  ADDR_W  saved exception PC.
- in_handler  out  1  executing inside an exception handler.
- halted  out  1  double fault occurred; PC frozen.
- exc_cnt  out  8  number of exceptions taken, saturating.

Behaviour:
- State machine RUN / HANDLER / HALT. `in_handler` = (state == HANDLER); `halted` = (state == HALT).
- Reset (`rst` = 0, asynchronous, with immediate effect):
  - `pc` = RESET_VEC, `epc` = 0, state RUN, `exc_cnt` = 0.
  - Reset asserted mid-handler or mid-halt returns to RUN with the same values.
  - Release is sampled synchronously; the first update occurs on the first rising edge with `rst` = 1.
- Misaligned redirect: `br_valid` with `br_target[1:0] != 0` is treated as an exception with cause MISALIGN_CAUSE; the branch is discarded.
- Effective exception: `exc_req` OR misaligned redirect. If both are present, `exc_cause` wins.
- Per-edge priority in RUN:
  1. effective exception: `epc` <= `pc`; `pc` <= EXC_BASE + (cause << VEC_SHIFT); state -> HANDLER; `exc_cnt` +1.
  2. `stall`: `pc` holds; `br_valid` is ignored, so upstream must hold the request until `stall` drops.
  3. `br_valid`: `pc` <= `br_target`.
  4. otherwise: `pc` <= `pc` + 4.
  - `eret` in RUN is ignored; sequential fetch continues.
- HANDLER: same priority, except:
  - An effective exception goes to HALT. `pc` and `epc` hold; `exc_cnt` still increments.
  - `eret` sits between the exception and `stall` in priority: `pc` <= `epc`; state -> RUN. `eret` overrides `stall` and `br_valid`.
- HALT: all inputs ignored; `pc`, `epc` and `exc_cnt` hold until reset.
- Arithmetic is modulo 2^ADDR_W: `pc` = {1…1,00} + 4 wraps to 0 with no flag. Vector offset = cause << VEC_SHIFT, zero-extended to ADDR_W.
- `exc_cnt` saturates at 255 and never wraps.
- Latency: every redirect, vector or return is visible on `pc` the cycle after the request edge. All outputs are registered; there is no combinational path from input to `pc`.
- Exceptions override `stall`: a stalled instruction that raises a fault still traps.

Test Plan:
- Reset then 3 free cycles -> `pc` = 0, 4, 8, 0xC; `exc_cnt` = 0; `in_handler` = 0.
- `pc` = 0x20, `exc_req` = 1, `exc_cause` = 2 -> next `pc` = 0x820, `epc` = 0x20, `in_handler` = 1, `exc_cnt` = 1. Then `eret` with `stall` = 1 -> `pc` = 0x20, `in_handler` = 0.
- `br_valid` with `br_target` = 0x102 at `pc` = 0x40 -> `pc` = 0x870, `epc` = 0x40, cause 7 vector. `br_valid` 0x100 with `stall` = 1 -> `pc` holds at its value.
- Exception while `in_handler` -> `halted` = 1; `pc` frozen across 10 cycles of `br_valid`/`eret`. Assert `rst` = 0 asynchronously between edges -> `pc` = 0 immediately, `halted` = 0.
- Exception taken 300 times with `eret` between each -> `exc_cnt` = 255. `pc` = 0xFFFF_FFFC free-running -> next `pc` = 0.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: stall, branch redirect, cause-indexed exception vectors, EPC/ERET, double-fault halt.
// Latency: every pc/epc/state change is visible one cycle after the requesting edge; all outputs registered.
// Backpressure: stall holds pc and drops br_valid (upstream re-presents it); exceptions and eret override stall.
//
// Ports:
//   clk, rst (async active-low)        clock and reset
//   stall, br_valid, br_target         hold / redirect requests from next-PC logic
//   exc_req, exc_cause, eret           exception request with cause, return-from-exception
//   pc, epc                            fetch address, saved exception PC
//   in_handler, halted, exc_cnt        handler/halt status and saturating exception count
module pc_seq_ctrl #(
    parameter int                   ADDR_W         = 32,
    parameter logic [ADDR_W-1:0]    RESET_VEC      = 32'h0000_0000,
    parameter logic [ADDR_W-1:0]    EXC_BASE       = 32'h0000_0800,
    parameter int                   CAUSE_W        = 3,
    parameter int                   VEC_SHIFT      = 4,
    parameter logic [CAUSE_W-1:0]   MISALIGN_CAUSE = 3'b111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                br_valid,
    input  logic [ADDR_W-1:0]   br_target,
    input  logic                exc_req,
    input  logic [CAUSE_W-1:0]  exc_cause,
    input  logic                eret,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   epc,
    output logic                in_handler,
    output logic                halted,
    output logic [7:0]          exc_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HANDLER = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   epc_q, epc_d;
    logic [7:0]          exc_cnt_q, exc_cnt_d;

    logic                misalign;
    logic                exc_eff;
    logic [CAUSE_W-1:0]  cause;
    logic [ADDR_W-1:0]   vec_addr;
    logic [ADDR_W-1:0]   pc_seq;
    logic [7:0]          exc_cnt_inc;

    always_comb begin
        // A misaligned redirect becomes a trap; an explicit request's cause takes precedence.
        misalign    = br_valid && (br_target[1:0] != 2'b00);
        exc_eff     = exc_req || misalign;
        cause       = exc_req ? exc_cause : MISALIGN_CAUSE;
        vec_addr    = EXC_BASE + ({{(ADDR_W-CAUSE_W){1'b0}}, cause} << VEC_SHIFT);
        exc_cnt_inc = (exc_cnt_q == 8'hFF) ? exc_cnt_q : exc_cnt_q + 8'd1;

        // Normal flow shared by RUN and HANDLER once exceptions/eret are resolved.
        if (stall) begin
            pc_seq = pc_q;
        end else if (br_valid) begin
            pc_seq = br_target;
        end else begin
            pc_seq = pc_q + ADDR_W'(4);
        end

        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        exc_cnt_d = exc_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (exc_eff) begin
                    epc_d     = pc_q;
                    pc_d      = vec_addr;
                    exc_cnt_d = exc_cnt_inc;
                    state_d   = ST_HANDLER;
                end else begin
                    pc_d = pc_seq;
                end
            end
            ST_HANDLER: begin
                if (exc_eff) begin
                    // Fault inside the handler: freeze pc/epc for post-mortem.
                    exc_cnt_d = exc_cnt_inc;
                    state_d   = ST_HALT;
                end else if (eret) begin
                    pc_d    = epc_q;
                    state_d = ST_RUN;
                end else begin
                    pc_d = pc_seq;
                end
            end
            default: begin
                // ST_HALT: only reset leaves this state.
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_VEC;
            epc_q     <= '0;
            exc_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            exc_cnt_q <= exc_cnt_d;
        end
    end

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign in_handler = (state_q == ST_HANDLER);
    assign halted     = (state_q == ST_HALT);
    assign exc_cnt    = exc_cnt_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios plus randomized traffic against a reference model.
// Latency: model advances on each rising edge, outputs compared 1 time unit later.
// Backpressure: stall driven randomly; model drops redirects presented during stall.
module tb_pc_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic [2:0]  exc_cause;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        in_handler;
    logic        halted;
    logic [7:0]  exc_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state, expressed as plain values and flags.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_in_handler;
    bit          m_halted;
    int          m_cnt;

    pc_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .exc_cause  (exc_cause),
        .eret       (eret),
        .pc         (pc),
        .epc        (epc),
        .in_handler (in_handler),
        .halted     (halted),
        .exc_cnt    (exc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc         = 32'h0;
        m_epc        = 32'h0;
        m_in_handler = 0;
        m_halted     = 0;
        m_cnt        = 0;
    endtask

    task automatic model_edge();
        bit          mis;
        bit          exc;
        int unsigned cause;
        if (!rst || m_halted) return;
        mis   = br_valid && (br_target % 4 != 0);
        exc   = exc_req || mis;
        cause = exc_req ? exc_cause : 7;
        if (exc) begin
            if (m_in_handler) begin
                m_in_handler = 0;
                m_halted     = 1;
            end else begin
                m_epc        = m_pc;
                m_pc         = 32'h800 + cause * 16;
                m_in_handler = 1;
            end
            if (m_cnt < 255) m_cnt++;
        end else if (m_in_handler && eret) begin
            m_pc         = m_epc;
            m_in_handler = 0;
        end else if (stall) begin
            // hold
        end else if (br_valid) begin
            m_pc = br_target;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},  pc,  m_pc);
        check({tag, ".epc"}, epc, m_epc);
        check({tag, ".hnd"}, {31'b0, in_handler}, {31'b0, m_in_handler});
        check({tag, ".hlt"}, {31'b0, halted},     {31'b0, m_halted});
        check({tag, ".cnt"}, {24'b0, exc_cnt},    m_cnt);
    endtask

    // One rising edge: model follows the inputs present at the edge, outputs checked just after.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        stall     = 0;
        br_valid  = 0;
        br_target = 32'h0;
        exc_req   = 0;
        exc_cause = 3'd0;
        eret      = 0;
    endtask

    // Assert reset between edges and check it acts without a clock edge.
    task automatic async_reset(input string tag);
        #3;
        rst = 0;
        model_reset();
        #1;
        check_all(tag);
        cycle({tag, ".hold"});
        rst = 1;
    endtask

    initial begin
        logic [31:0] t;
        rst = 0;
        idle();
        model_reset();
        #1;
        check_all("rst0");
        cycle("rst1");
        cycle("rst2");
        check("rst_pc", pc, 32'h0);
        rst = 1;

        // Free running after release.
        cycle("free1"); check("free_pc1", pc, 32'h4);
        cycle("free2"); check("free_pc2", pc, 32'h8);
        cycle("free3"); check("free_pc3", pc, 32'hC);
        check("free_cnt", {24'b0, exc_cnt}, 32'd0);

        // Exception cause 2 at pc 0x20, then eret under stall.
        br_valid = 1; br_target = 32'h20;
        cycle("br20");
        idle(); exc_req = 1; exc_cause = 3'd2;
        cycle("exc2");
        check("exc2_pc", pc, 32'h820);
        check("exc2_epc", epc, 32'h20);
        check("exc2_hnd", {31'b0, in_handler}, 32'd1);
        check("exc2_cnt", {24'b0, exc_cnt}, 32'd1);
        idle(); eret = 1; stall = 1;
        cycle("eret_stall");
        check("eret_pc", pc, 32'h20);
        check("eret_hnd", {31'b0, in_handler}, 32'd0);

        // Misaligned redirect traps with cause 7.
        idle(); br_valid = 1; br_target = 32'h40;
        cycle("br40");
        br_target = 32'h102;
        cycle("mis");
        check("mis_pc", pc, 32'h870);
        check("mis_epc", epc, 32'h40);
        idle(); br_valid = 1; br_target = 32'h100; stall = 1;
        cycle("stall_br");
        check("stall_pc", pc, 32'h870);

        // Double fault, then frozen pc under redirect/eret traffic.
        idle(); exc_req = 1; exc_cause = 3'd1;
        cycle("dfault");
        check("dfault_hlt", {31'b0, halted}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            idle(); br_valid = 1; br_target = 32'h200 + 32'(i) * 4; eret = (i % 2 == 0);
            cycle("halt_frz");
            check("halt_pc", pc, 32'h870);
        end
        idle();
        async_reset("arst");
        check("arst_pc", pc, 32'h0);
        check("arst_hlt", {31'b0, halted}, 32'd0);

        // Counter saturation over 300 exception/eret pairs.
        for (int i = 0; i < 300; i++) begin
            idle(); exc_req = 1; exc_cause = 3'(i);
            cycle("sat_exc");
            idle(); eret = 1;
            cycle("sat_eret");
        end
        check("sat_cnt", {24'b0, exc_cnt}, 32'd255);

        // Wrap at top of address space.
        idle(); br_valid = 1; br_target = 32'hFFFF_FFFC;
        cycle("br_top");
        idle();
        cycle("wrap");
        check("wrap_pc", pc, 32'h0);

        // Randomized traffic; occasional async reset recovers from halt.
        for (int i = 0; i < 2000; i++) begin
            idle();
            stall    = ($urandom_range(0, 3) == 0);
            br_valid = ($urandom_range(0, 3) == 0);
            t = $urandom();
            if ($urandom_range(0, 5) != 0) t[1:0] = 2'b00;
            br_target = t;
            exc_req   = ($urandom_range(0, 15) == 0);
            exc_cause = 3'($urandom_range(0, 7));
            eret      = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0) begin
                idle();
                async_reset("rnd_rst");
            end else begin
                cycle("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
